// File: rtl/reg_mask_encoder.sv
// reg_mask_encoder: serialises a register mask into lowest-first register indices
module reg_mask_encoder #(
  parameter int NREG = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NREG-1:0] in_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic [IDXW:0]   out_cnt,
  output logic            busy
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] rest;
  logic [IDXW:0] cnt;
  assign rest = pending & (pending - NREG'(1));
  assign in_ready = (state == IDLE) & ~rst;
  assign out_valid = state == EMIT;
  assign busy = state == EMIT;
  assign out_last = out_valid & ~|rest;
  // index of the lowest pending set bit
  always_comb begin
    out_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) out_idx = pending[i] ? IDXW'(i) : out_idx;
  end
  // popcount of the incoming mask
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREG; i++) cnt = cnt + (IDXW + 1)'(in_mask[i]);
  end
  // accept masks in IDLE, retire the lowest pending bit on each handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      out_cnt <= '0;
    end else if (state == IDLE) begin
      if (in_valid && |in_mask) begin
        pending <= in_mask;
        out_cnt <= cnt;
        state   <= EMIT;
      end
    end else if (out_ready) begin
      pending <= rest;
      if (out_last) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_reg_mask_encoder.sv
// tb_reg_mask_encoder: randomized self-checking bench against a queue-based model
module tb_reg_mask_encoder;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] in_mask = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [2:0] out_idx;
  logic [3:0] out_cnt;
  int n_checks = 0, n_fail = 0;

  reg_mask_encoder #(.NREG(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .out_cnt(out_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1;
    #1;
    n_checks++; if ({out_valid, busy, out_last, in_ready} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {out_valid, busy, out_last, in_ready}); end
    n_checks++; if ({out_idx, out_cnt} !== 7'b0) begin n_fail++; $display("FAIL reset_vals got idx=%0d cnt=%0d want 0,0", out_idx, out_cnt); end
    @(negedge clk); rst = 0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release in_ready got %b want 1", in_ready); end
  endtask

  task automatic run_mask(input logic [7:0] mask, input int stall_pct, input logic [3:0] prev_cnt);
    logic [2:0] q[$];
    int cyc = 0;
    int k;
    for (int i = 0; i < 8; i++) if (mask[i]) q.push_back(3'(i));
    k = q.size();
    @(negedge clk); in_valid = 1; in_mask = mask; out_ready = 0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready mask=%h got %b want 1", mask, in_ready); end
    @(negedge clk); in_valid = 0;
    if (k == 0) begin
      n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_mask valid/busy got %b want 00", {out_valid, busy}); end
      n_checks++; if (out_cnt !== prev_cnt) begin n_fail++; $display("FAIL zero_mask out_cnt got %0d want %0d", out_cnt, prev_cnt); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_mask in_ready got %b want 1", in_ready); end
      return;
    end
    while (q.size() > 0 && cyc < 200) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      n_checks++; if ({out_valid, busy, in_ready} !== 3'b110) begin n_fail++; $display("FAIL beat_flags mask=%h got %b want 110", mask, {out_valid, busy, in_ready}); end
      n_checks++; if (out_idx !== q[0]) begin n_fail++; $display("FAIL beat_idx mask=%h got %0d want %0d", mask, out_idx, q[0]); end
      n_checks++; if (out_last !== (q.size() == 1)) begin n_fail++; $display("FAIL beat_last mask=%h idx=%0d got %b want %b", mask, q[0], out_last, q.size() == 1); end
      n_checks++; if (out_cnt !== 4'($countones(mask))) begin n_fail++; $display("FAIL beat_cnt mask=%h got %0d want %0d", mask, out_cnt, $countones(mask)); end
      @(posedge clk);
      if (out_ready) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    out_ready = 0;
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL drain_timeout mask=%h left %0d want 0", mask, q.size()); end
    if (stall_pct == 0) begin
      n_checks++; if (cyc != k) begin n_fail++; $display("FAIL beat_count mask=%h got %0d cycles want %0d", mask, cyc, k); end
    end
    n_checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin n_fail++; $display("FAIL done_flags mask=%h got %b want 001", mask, {out_valid, busy, in_ready}); end
  endtask

  task automatic test_basic();
    run_mask(8'hA4, 0, 4'd0);
    run_mask(8'hFF, 0, 4'd3);
  endtask

  task automatic test_zero_mask();
    run_mask(8'h00, 0, 4'd8);
  endtask

  task automatic test_stall();
    @(negedge clk); in_valid = 1; in_mask = 8'h81; out_ready = 0;
    @(negedge clk); in_valid = 0;
    for (int c = 0; c < 5; c++) begin
      out_ready = (c == 4);
      n_checks++; if ({out_valid, out_idx, out_last} !== {1'b1, 3'd0, 1'b0}) begin n_fail++; $display("FAIL stall_hold cyc=%0d got v=%b idx=%0d last=%b want 1,0,0", c, out_valid, out_idx, out_last); end
      @(negedge clk);
    end
    n_checks++; if ({out_valid, out_idx, out_last} !== {1'b1, 3'd7, 1'b1}) begin n_fail++; $display("FAIL stall_second got v=%b idx=%0d last=%b want 1,7,1", out_valid, out_idx, out_last); end
    @(negedge clk); out_ready = 0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_done got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); in_valid = 1; in_mask = 8'h30; out_ready = 1;
    @(negedge clk); in_mask = 8'h0F;
    n_checks++; if ({in_ready, out_idx, out_last} !== {1'b0, 3'd4, 1'b0}) begin n_fail++; $display("FAIL b2b_first got rdy=%b idx=%0d last=%b want 0,4,0", in_ready, out_idx, out_last); end
    @(negedge clk);
    n_checks++; if ({in_ready, out_idx, out_last} !== {1'b0, 3'd5, 1'b1}) begin n_fail++; $display("FAIL b2b_second got rdy=%b idx=%0d last=%b want 0,5,1", in_ready, out_idx, out_last); end
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_gap got %b want 01", {out_valid, in_ready}); end
    @(negedge clk); in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({out_valid, out_idx, out_last, out_cnt} !== {1'b1, 3'(i), i == 3, 4'd4}) begin n_fail++; $display("FAIL b2b_next i=%0d got v=%b idx=%0d last=%b cnt=%0d want 1,%0d,%0d,4", i, out_valid, out_idx, out_last, out_cnt, i, i == 3); end
      @(negedge clk);
    end
    out_ready = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); in_valid = 1; in_mask = 8'h1C; out_ready = 1;
    @(negedge clk); in_valid = 0;
    n_checks++; if (out_idx !== 3'd2) begin n_fail++; $display("FAIL mrst_first got %0d want 2", out_idx); end
    @(negedge clk);
    rst = 1; #1;
    n_checks++; if ({out_valid, busy, out_last, in_ready, out_idx, out_cnt} !== 11'b0) begin n_fail++; $display("FAIL mrst_clear got v=%b b=%b l=%b r=%b idx=%0d cnt=%0d want all 0", out_valid, busy, out_last, in_ready, out_idx, out_cnt); end
    @(negedge clk); rst = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL mrst_after cyc=%0d got %b want 01", c, {out_valid, in_ready}); end
      @(negedge clk);
    end
    out_ready = 0;
  endtask

  task automatic test_random();
    logic [3:0] last_cnt;
    logic [7:0] m;
    last_cnt = 4'd0;
    for (int n = 0; n < 30; n++) begin
      m = 8'($urandom_range(255));
      if (n % 7 == 0) m = 8'(1 << $urandom_range(7));
      run_mask(m, 40, last_cnt);
      if (m != 0) last_cnt = 4'($countones(m));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
